// File: rtl/note_sequencer.sv
// note_sequencer: one round of the guitar game.
// Sequences a 4-beat count-in, beat-timed note scrolling down each lane,
// judging of strums against the strike row (row 0), and score/miss totals.
// Optional build macro COMBO_EN: tracks a hit streak in combo, and a hit
// made while the streak is already 8 or more is worth 2 points.
// With COMBO_EN undefined, combo stays 0 and every hit is worth 1 point.
module note_sequencer #(
    parameter int NUM_LANES = 4,
    parameter int DEPTH     = 8,
    parameter int TEMPO_DIV = 3_000_000,
    parameter int SONG_LEN  = 32,
    parameter int ADDR_W    = 5,
    parameter int SCORE_W   = 8
) (
    input  logic                         clk,
    input  logic                         n_rst,
    input  logic [2:0]                   mode,
    input  logic [NUM_LANES-1:0]         lane_btn,
    input  logic [NUM_LANES-1:0]         pattern,
    output logic [ADDR_W-1:0]            pattern_addr,
    output logic [NUM_LANES*DEPTH-1:0]   disp,
    output logic [SCORE_W-1:0]           score,
    output logic [SCORE_W-1:0]           misses,
    output logic [SCORE_W-1:0]           combo,
    output logic                         hit,
    output logic                         miss,
    output logic                         done,
    output logic                         beat
);

    localparam int DIV_W = (TEMPO_DIV > 1) ? $clog2(TEMPO_DIV) : 1;
    localparam int CNT_W = $clog2(2 * NUM_LANES + 1);
    localparam int SUM_W = SCORE_W + CNT_W;
    localparam logic [DIV_W-1:0]   DIV_MAX   = DIV_W'(TEMPO_DIV - 1);
    localparam logic [ADDR_W-1:0]  IDX_LAST  = ADDR_W'(SONG_LEN - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COUNT = 3'd1,
        S_PLAY  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                       r_state;
    state_t                       w_state_nxt;

    logic [DIV_W-1:0]             r_div;
    logic [1:0]                   r_cnt;
    logic [ADDR_W-1:0]            r_idx;
    logic [NUM_LANES*DEPTH-1:0]   r_disp;
    logic [SCORE_W-1:0]           r_score;
    logic [SCORE_W-1:0]           r_misses;
    logic [SCORE_W-1:0]           r_combo;
    logic                         r_hit;
    logic                         r_miss;
    logic                         r_done;
    logic                         r_beat;

    logic                         w_mode_play;
    logic                         w_mode_pause;
    logic                         w_mode_idle;
    logic                         w_active;
    logic                         w_run;
    logic                         w_tick;
    logic                         w_judge;
    logic                         w_shift;
    logic                         w_load;

    logic [NUM_LANES-1:0]         w_row0;
    logic [NUM_LANES-1:0]         w_press;
    logic [NUM_LANES-1:0]         w_hit_vec;
    logic [NUM_LANES-1:0]         w_miss_vec;
    logic [NUM_LANES*DEPTH-1:0]   w_disp_nxt;
    logic [CNT_W-1:0]             w_nhit;
    logic [CNT_W-1:0]             w_nmiss;
    logic [CNT_W-1:0]             w_score_inc;
    logic [SCORE_W-1:0]           w_combo_nxt;

    function automatic logic [CNT_W-1:0] popcount(input logic [NUM_LANES-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            n = n + CNT_W'(v[i]);
        end
        return n;
    endfunction

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                   input logic [CNT_W-1:0]   b);
        logic [SUM_W-1:0] s;
        s = SUM_W'(a) + SUM_W'(b);
        if (s > SUM_W'(SCORE_MAX)) begin
            return SCORE_MAX;
        end
        return s[SCORE_W-1:0];
    endfunction

    // Anything other than a clean PLAY or PAUSE code behaves as IDLE.
    assign w_mode_play  = (mode == 3'b010);
    assign w_mode_pause = (mode == 3'b100);
    assign w_mode_idle  = !(w_mode_play || w_mode_pause);

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; an IDLE mode aborts the round from any state.
    always_comb begin
        w_state_nxt = r_state;
        if (r_state != S_IDLE && w_mode_idle) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_mode_play)                      w_state_nxt = S_COUNT;
                S_COUNT: if (w_tick && r_cnt == 2'd3)          w_state_nxt = S_PLAY;
                S_PLAY:  if (w_shift && r_idx == IDX_LAST)     w_state_nxt = S_DRAIN;
                S_DRAIN: if (w_shift && w_disp_nxt == '0)      w_state_nxt = S_DONE;
                default: ;
            endcase
        end
    end

    // State decode: the divider only runs while a round is live and unpaused.
    always_comb begin
        w_active = (r_state == S_COUNT) || (r_state == S_PLAY) || (r_state == S_DRAIN);
        w_run    = w_active && w_mode_play;
        w_tick   = w_run && (r_div == DIV_MAX);
        w_judge  = w_mode_play && ((r_state == S_PLAY) || (r_state == S_DRAIN));
        w_shift  = w_tick && ((r_state == S_PLAY) || (r_state == S_DRAIN));
        w_load   = (r_state == S_PLAY);
    end

    // Per-lane image update: a hit clears the strike row, a tick scrolls down
    // and loads the top row (pattern while playing, empty while draining).
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        logic [DEPTH-1:0] w_cur;
        logic [DEPTH-1:0] w_shifted;
        logic [DEPTH-1:0] w_held;
        assign w_cur     = r_disp[l*DEPTH +: DEPTH];
        assign w_row0[l] = w_cur[0];
        assign w_shifted = {w_load & pattern[l], w_cur[DEPTH-1:1]};
        assign w_held    = {w_cur[DEPTH-1:1], w_cur[0] & ~w_hit_vec[l]};
        assign w_disp_nxt[l*DEPTH +: DEPTH] = w_shift ? w_shifted : w_held;
    end

    // Judging against the pre-shift strike row; a note hit this cycle is
    // never also counted as a shift-out miss.
    always_comb begin
        w_press    = w_judge ? lane_btn : '0;
        w_hit_vec  = w_press & w_row0;
        w_miss_vec = (w_press & ~w_row0) | (w_shift ? (w_row0 & ~w_hit_vec) : '0);
        w_nhit     = popcount(w_hit_vec);
        w_nmiss    = popcount(w_miss_vec);
`ifdef COMBO_EN
        w_score_inc = (32'(r_combo) >= 32'd8) ? (w_nhit << 1) : w_nhit;
        w_combo_nxt = (|w_miss_vec) ? '0 : sat_add(r_combo, w_nhit);
`else
        w_score_inc = w_nhit;
        w_combo_nxt = '0;
`endif
    end

    // Round datapath; everything clears on the way into IDLE.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_div    <= '0;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_disp   <= '0;
            r_score  <= '0;
            r_misses <= '0;
            r_combo  <= '0;
            r_hit    <= 1'b0;
            r_miss   <= 1'b0;
            r_done   <= 1'b0;
            r_beat   <= 1'b0;
        end else if (w_state_nxt == S_IDLE) begin
            r_div    <= '0;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_disp   <= '0;
            r_score  <= '0;
            r_misses <= '0;
            r_combo  <= '0;
            r_hit    <= 1'b0;
            r_miss   <= 1'b0;
            r_done   <= 1'b0;
            r_beat   <= 1'b0;
        end else begin
            if (w_run) begin
                r_div <= w_tick ? '0 : r_div + DIV_W'(1);
            end
            if (w_tick && r_state == S_COUNT) begin
                r_cnt <= r_cnt + 2'd1;
            end
            if (w_shift && r_state == S_PLAY) begin
                r_idx <= r_idx + ADDR_W'(1);
            end
            r_disp   <= w_disp_nxt;
            r_score  <= sat_add(r_score, w_score_inc);
            r_misses <= sat_add(r_misses, w_nmiss);
            r_combo  <= w_combo_nxt;
            r_hit    <= |w_hit_vec;
            r_miss   <= |w_miss_vec;
            r_beat   <= w_tick;
            r_done   <= (w_state_nxt == S_DONE);
        end
    end

    assign pattern_addr = r_idx;
    assign disp         = r_disp;
    assign score        = r_score;
    assign misses       = r_misses;
    assign combo        = r_combo;
    assign hit          = r_hit;
    assign miss         = r_miss;
    assign done         = r_done;
    assign beat         = r_beat;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with a short beat (TEMPO_DIV=4).
module tb_note_sequencer;

    localparam int NL = 4;
    localparam int DP = 8;
    localparam int TD = 4;
    localparam int SL = 32;
    localparam int AW = 5;
    localparam int SW = 8;

    localparam logic [2:0] M_IDLE  = 3'b001;
    localparam logic [2:0] M_PLAY  = 3'b010;
    localparam logic [2:0] M_PAUSE = 3'b100;

`ifdef COMBO_EN
    localparam int STREAK_SCORE = 12;
    localparam int STREAK_COMBO = 10;
`else
    localparam int STREAK_SCORE = 10;
    localparam int STREAK_COMBO = 0;
`endif

    logic              clk = 1'b0;
    logic              n_rst;
    logic [2:0]        mode;
    logic [NL-1:0]     lane_btn;
    logic [NL-1:0]     pattern;
    logic [AW-1:0]     pattern_addr;
    logic [NL*DP-1:0]  disp;
    logic [SW-1:0]     score;
    logic [SW-1:0]     misses;
    logic [SW-1:0]     combo;
    logic              hit;
    logic              miss;
    logic              done;
    logic              beat;

    logic [NL-1:0]     rom [0:SL-1];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign pattern = rom[pattern_addr];

    note_sequencer #(
        .NUM_LANES (NL),
        .DEPTH     (DP),
        .TEMPO_DIV (TD),
        .SONG_LEN  (SL),
        .ADDR_W    (AW),
        .SCORE_W   (SW)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .mode         (mode),
        .lane_btn     (lane_btn),
        .pattern      (pattern),
        .pattern_addr (pattern_addr),
        .disp         (disp),
        .score        (score),
        .misses       (misses),
        .combo        (combo),
        .hit          (hit),
        .miss         (miss),
        .done         (done),
        .beat         (beat)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < SL; i++) rom[i] = '0;
    endtask

    task automatic go_idle();
        mode     = M_IDLE;
        lane_btn = '0;
        step();
        step();
    endtask

    task automatic wait_beats(input int n);
        for (int i = 0; i < n; i++) begin
            int c;
            c = 0;
            do begin
                step();
                c++;
            end while (beat !== 1'b1 && c < 64);
            if (beat !== 1'b1) check_eq("beat_timeout", 64'(beat), 64'd1);
        end
    endtask

    // Starts a round and returns right after the 4th count-in beat.
    task automatic start_round();
        int c;
        mode = M_PLAY;
        c = 0;
        do begin
            step();
            c++;
        end while (beat !== 1'b1 && c < 64);
        check_eq("first_beat_latency", 64'(c), 64'(TD + 1));
        wait_beats(3);
    endtask

    task automatic press(input logic [NL-1:0] v);
        lane_btn = v;
        step();
        lane_btn = '0;
    endtask

    initial begin
        int c;
        int nb;
        int nj;

        n_rst    = 1'b0;
        mode     = M_IDLE;
        lane_btn = '0;
        clear_rom();
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_outputs", {pattern_addr, score, misses, combo, hit, miss, done, beat}, '0);
        check_eq("reset_disp", disp, '0);
        n_rst = 1'b1;
        step();

        // Single note on lane 0, hit while at the strike row, then drain.
        rom[0] = 4'b0001;
        start_round();
        wait_beats(1);
        check_eq("t1_disp_top", disp, 32'h0000_0080);
        check_eq("t1_addr1", pattern_addr, 1);
        wait_beats(7);
        check_eq("t1_disp_row0", disp, 32'h0000_0001);
        check_eq("t1_addr8", pattern_addr, 8);
        press(4'b0001);
        check_eq("t1_hit", hit, 1);
        check_eq("t1_score", score, 1);
        check_eq("t1_misses", misses, 0);
        check_eq("t1_disp_cleared", disp, 0);
        c = 0;
        while (done !== 1'b1 && c < 400) begin
            step();
            c++;
        end
        check_eq("t1_done", done, 1);
        check_eq("t1_done_score", score, 1);
        check_eq("t1_done_misses", misses, 0);
        mode = M_IDLE;
        step();
        check_eq("t1_idle_done", done, 0);
        check_eq("t1_idle_score", score, 0);

        // Same note, no press: missed when it shifts out.
        go_idle();
        start_round();
        wait_beats(8);
        check_eq("t2_row0", disp, 32'h0000_0001);
        wait_beats(1);
        check_eq("t2_miss", miss, 1);
        check_eq("t2_misses", misses, 1);
        check_eq("t2_score", score, 0);
        check_eq("t2_disp", disp, 0);
        step();
        check_eq("t2_miss_pulse", miss, 0);

        // Hit on lane 0 and bad strum on lane 2 in the same cycle.
        go_idle();
        start_round();
        wait_beats(8);
        press(4'b0101);
        check_eq("t3_score", score, 1);
        check_eq("t3_misses", misses, 1);
        check_eq("t3_hit", hit, 1);
        check_eq("t3_miss", miss, 1);
        wait_beats(1);
        check_eq("t3_no_shiftout", misses, 1);

        // Press on lane 3 in the same cycle as the tick that would shift it out.
        go_idle();
        clear_rom();
        rom[0] = 4'b1000;
        start_round();
        wait_beats(8);
        check_eq("t4_row0", disp, 32'h0100_0000);
        step();
        step();
        step();
        press(4'b1000);
        check_eq("t4_beat", beat, 1);
        check_eq("t4_hit", hit, 1);
        check_eq("t4_miss", miss, 0);
        check_eq("t4_score", score, 1);
        check_eq("t4_misses", misses, 0);
        check_eq("t4_disp", disp, 0);

        // Three hits plus one bad strum in one cycle.
        go_idle();
        clear_rom();
        rom[0] = 4'b1011;
        start_round();
        wait_beats(8);
        check_eq("t5_row0", disp, 32'h0100_0101);
        press(4'b1111);
        check_eq("t5_score", score, 3);
        check_eq("t5_misses", misses, 1);

        // Pause mid-play: no beats, frozen image, presses ignored.
        go_idle();
        clear_rom();
        rom[0] = 4'b0001;
        start_round();
        wait_beats(2);
        check_eq("t6_disp_pre", disp, 32'h0000_0040);
        step();
        mode = M_PAUSE;
        nb = 0;
        nj = 0;
        for (int i = 0; i < 100; i++) begin
            lane_btn = (i == 10) ? 4'b0010 : ((i == 50) ? 4'b0001 : 4'b0000);
            step();
            if (beat === 1'b1) nb++;
            if (hit === 1'b1 || miss === 1'b1) nj++;
        end
        lane_btn = '0;
        check_eq("t6_no_beat", 64'(nb), 0);
        check_eq("t6_no_judge", 64'(nj), 0);
        check_eq("t6_disp_frozen", disp, 32'h0000_0040);
        check_eq("t6_misses", misses, 0);
        check_eq("t6_addr", pattern_addr, 2);
        mode = M_PLAY;
        c = 0;
        do begin
            step();
            c++;
        end while (beat !== 1'b1 && c < 64);
        check_eq("t6_resume_beat", 64'(c), 3);
        check_eq("t6_disp_post", disp, 32'h0000_0020);
        mode = M_IDLE;
        step();
        check_eq("t6_abort_disp", disp, 0);
        check_eq("t6_abort_addr", pattern_addr, 0);

        // Ten consecutive hits, then a bad strum.
        go_idle();
        clear_rom();
        for (int i = 0; i < 10; i++) rom[i] = 4'b0001;
        start_round();
        wait_beats(8);
        for (int i = 0; i < 10; i++) begin
            press(4'b0001);
            if (i < 9) wait_beats(1);
        end
        check_eq("t7_score", score, STREAK_SCORE);
        check_eq("t7_combo", combo, STREAK_COMBO);
        check_eq("t7_misses", misses, 0);
        press(4'b0010);
        check_eq("t7_miss_misses", misses, 1);
        check_eq("t7_miss_pulse", miss, 1);
        check_eq("t7_miss_combo", combo, 0);
        check_eq("t7_miss_score", score, STREAK_SCORE);

        // Asynchronous reset in the middle of a round with score 5.
        go_idle();
        clear_rom();
        for (int i = 0; i < 5; i++) rom[i] = 4'b0001;
        start_round();
        wait_beats(8);
        for (int i = 0; i < 5; i++) begin
            press(4'b0001);
            if (i < 4) wait_beats(1);
        end
        check_eq("t8_score_pre", score, 5);
        #3;
        n_rst = 1'b0;
        #1;
        check_eq("t8_rst_outputs", {pattern_addr, score, misses, combo, hit, miss, done, beat}, '0);
        check_eq("t8_rst_disp", disp, '0);
        mode = M_IDLE;
        step();
        n_rst = 1'b1;
        step();
        step();
        check_eq("t8_idle_outputs", {pattern_addr, score, misses, combo, hit, miss, done, beat}, '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
        $fatal(1);
    end

endmodule

// File: doc/note_sequencer.md
# note_sequencer

Game-round controller for the guitar game. It sits between the mode-select FSM and the LED/score datapath and sequences one song round: countdown, beat-timed note scrolling across lanes, judging of player strums, and score/miss accounting. It reads the note pattern from an external pattern ROM and drives the lane display and the score counters shown on the seven-segment logic.

## Interface
Parameters:
- NUM_LANES, 4, number of note lanes/buttons
- DEPTH, 8, rows per lane (row DEPTH-1 = top/spawn, row 0 = strike row)
- TEMPO_DIV, 3_000_000, clk cycles per beat (≥2)
- SONG_LEN, 32, notes in a song (≤ 2^ADDR_W)
- ADDR_W, 5, pattern address width
- SCORE_W, 8, score/miss counter width

Ports:
- clk  in  1  system clock (hwclk)
- n_rst  in  1  asynchronous active-low reset
- mode  in  3  from mode FSM, one-hot: 3'b001 IDLE, 3'b010 PLAY, 3'b100 PAUSE; any other value treated as IDLE
- lane_btn  in  NUM_LANES  one-cycle press pulses (already synchronized and edge-detected)
- pattern  in  NUM_LANES  ROM data for pattern_addr, valid combinationally
- pattern_addr  out  ADDR_W  current note index
- disp  out  NUM_LANES*DEPTH  lane image; bit [l*DEPTH+r] = lane l, row r
- score  out  SCORE_W  hit count, saturating
- misses  out  SCORE_W  miss count, saturating
- combo  out  SCORE_W  current streak (0 when COMBO_EN undefined)
- hit, miss  out  1  one-cycle pulses on any hit / any miss that cycle
- done  out  1  high in DONE state
- beat  out  1  one-cycle pulse on each beat tick

## Operation
- States: IDLE, COUNT (4 beats), PLAY, DRAIN, DONE.
- IDLE: all counters, disp, note_idx cleared; beat divider held at 0. mode==PLAY -> COUNT.
- COUNT: 4 beat ticks, no spawn, no judging; 4th tick -> PLAY.
- PLAY: each tick shifts every lane down one row; top row loaded with pattern; note_idx++. Tick loading note SONG_LEN-1 -> DRAIN.
- DRAIN: ticks shift with zeros loaded; when disp all zero at a tick -> DONE.
- DONE: holds score/misses; mode==IDLE -> IDLE.
- PAUSE (mode==PAUSE in COUNT/PLAY/DRAIN): divider frozen, lane_btn ignored, state held; resume continues divider from frozen value.
- mode==IDLE in any state -> IDLE next cycle (abort).
- Judging (PLAY/DRAIN only, not paused), per lane, evaluated against pre-shift row 0:
  - press and row0 set -> hit: clear bit, score += 1.
  - press and row0 clear -> miss (bad strum), misses += 1.
  - tick shifting out row0 set (not hit this cycle) -> miss.
- Press and tick same cycle: press judged first; a hit note is not also counted as a shift-out miss.
- Multiple lanes same cycle: score/misses increase by popcount of hits/misses, saturating at 2^SCORE_W-1.

## Timing
- All outputs registered; reset value 0 for every output, state=IDLE.
- lane_btn at cycle N -> score/misses/hit/miss updated at N+1.
- beat pulses once every TEMPO_DIV cycles of unpaused COUNT/PLAY/DRAIN; first beat TEMPO_DIV cycles after entering COUNT.
- pattern sampled on tick cycle; pattern_addr changes the cycle after.
- A note loaded at tick k reaches row 0 after tick k+DEPTH-1, shifts out at tick k+DEPTH.
- n_rst asserted mid-round clears everything immediately.

## Configuration
- COMBO_EN defined: combo counts consecutive hits (saturating), reset to 0 on any miss; hit adds 2 to score when combo ≥ 8 before the hit, else 1.
- Undefined: combo tied 0; each hit adds 1.

## Test plan
- Reset mid-PLAY with score=5 -> all outputs 0, state IDLE, next cycle.
- DEPTH=8, TEMPO_DIV=4, pattern=4'b0001 at note 0 only, press lane0 during tick 4 after COUNT + 7 ticks -> score=1, misses=0, done after drain.
- Same pattern, no press -> misses=1 at shift-out tick, score=0.
- Press lane2 with row0 empty, plus lane0 hit same cycle -> score=1, misses=1, hit=miss=1.
- PAUSE for 100 cycles mid-PLAY -> no beat, disp unchanged, presses ignored; resume beat timing continues from frozen count.
- COMBO_EN, 10 consecutive hits -> score=12, combo=10; then a miss -> combo=0.
